// File: rtl/usrt_tx.sv
// USRT transmit engine: one-deep holding register feeding a start/data/stop
// serializer with a gated serial clock. Define USRT_TX_PARITY_EN to add an even-parity bit.
module usrt_tx #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 i_Pclk,
    input  logic                 i_Rst,
    input  logic                 i_Tx_En,
    input  logic [DATA_BITS-1:0] i_Pwdata,
    output logic                 o_Usrt_Clk,
    output logic                 o_Usrt_Tx,
    output logic                 o_Tx_Busy,
    output logic                 o_Tx_Done,
    output logic                 o_Tx_Ovr
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef USRT_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic [2:0]           state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 half_q, half_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 hold_vld_q, hold_vld_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
`ifdef USRT_TX_PARITY_EN
    logic                 par_q, par_d;
`endif
    logic                 clk_q, clk_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;

    logic                 div_wrap;
    logic                 bit_end;
    logic                 load;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        half_d     = half_q;
        idx_d      = idx_q;
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        shift_d    = shift_q;
`ifdef USRT_TX_PARITY_EN
        par_d      = par_q;
`endif
        clk_d      = clk_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        ovr_d      = 1'b0;
        load       = 1'b0;

        div_wrap = (div_q == DIV_LAST);
        bit_end  = div_wrap && half_q;

        if (state_q == IDLE) begin
            clk_d = 1'b1;
            tx_d  = 1'b1;
            load  = hold_vld_q;
        end else begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
            // Rising clock mid-bit; the falling edge and the new data bit share the bit boundary.
            if (div_wrap && !half_q) begin
                half_d = 1'b1;
                clk_d  = 1'b1;
            end
            if (bit_end) begin
                half_d = 1'b0;
                clk_d  = 1'b0;
                case (state_q)
                    START: begin
                        state_d = DATA;
                        idx_d   = '0;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                    DATA: begin
                        if (idx_q == IDX_LAST) begin
`ifdef USRT_TX_PARITY_EN
                            state_d = PARITY;
                            tx_d    = par_q;
`else
                            state_d = STOP;
                            tx_d    = 1'b1;
`endif
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            tx_d    = shift_q[0];
                            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        end
                    end
`ifdef USRT_TX_PARITY_EN
                    PARITY: begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
`endif
                    STOP: begin
                        done_d = 1'b1;
                        if (hold_vld_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                            clk_d   = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        clk_d   = 1'b1;
                    end
                endcase
            end
        end

        if (load) begin
            shift_d    = hold_q;
`ifdef USRT_TX_PARITY_EN
            par_d      = ^hold_q;
`endif
            hold_vld_d = 1'b0;
            state_d    = START;
            tx_d       = 1'b0;
            clk_d      = 1'b0;
            div_d      = '0;
            half_d     = 1'b0;
            idx_d      = '0;
        end

        // A write may refill the holding register on the same edge it empties.
        if (i_Tx_En) begin
            if (!hold_vld_q || load) begin
                hold_vld_d = 1'b1;
                hold_d     = i_Pwdata;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = hold_vld_d || (state_d != IDLE);
    end

    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            half_q     <= 1'b0;
            idx_q      <= '0;
            hold_vld_q <= 1'b0;
            clk_q      <= 1'b1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            half_q     <= half_d;
            idx_q      <= idx_d;
            hold_vld_q <= hold_vld_d;
            clk_q      <= clk_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    always_ff @(posedge i_Pclk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
`ifdef USRT_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

    assign o_Usrt_Clk = clk_q;
    assign o_Usrt_Tx  = tx_q;
    assign o_Tx_Busy  = busy_q;
    assign o_Tx_Done  = done_q;
    assign o_Tx_Ovr   = ovr_q;

endmodule

// File: tb/tb_usrt_tx.sv
// Bench for usrt_tx at CLK_DIV=2: frame-timeline model checked every cycle,
// plus directed frames with literal bit sequences.
module tb_usrt_tx;

    localparam int D  = 2;
    localparam int D2 = 2 * D;
`ifdef USRT_TX_PARITY_EN
    localparam int NB = 11;
    localparam int FR = 44;
`else
    localparam int NB = 10;
    localparam int FR = 40;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] wdata;
    logic       u_clk, u_tx, busy, done, ovr;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;

    always #5 clk = ~clk;

    usrt_tx #(.CLK_DIV(D), .DATA_BITS(8)) dut (
        .i_Pclk    (clk),
        .i_Rst     (rst),
        .i_Tx_En   (en),
        .i_Pwdata  (wdata),
        .o_Usrt_Clk(u_clk),
        .o_Usrt_Tx (u_tx),
        .o_Tx_Busy (busy),
        .o_Tx_Done (done),
        .o_Tx_Ovr  (ovr)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is a timeline t=0..FR-1; the line level follows from t alone.
    logic       m_init = 1'b0;
    logic       m_active, m_hold_vld;
    logic [7:0] m_byte, m_hold;
    int         m_t;
    logic       e_tx, e_clk, e_busy, e_done, e_ovr;

    task automatic model_step();
        int b;
        if (rst) begin
            m_init = 1'b1; m_active = 1'b0; m_hold_vld = 1'b0; m_t = 0;
            e_tx = 1'b1; e_clk = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ovr = 1'b0;
            return;
        end
        if (!m_init) return;
        e_done = 1'b0;
        e_ovr  = 1'b0;
        if (m_active) begin
            m_t++;
            if (m_t == FR) begin
                e_done   = 1'b1;
                m_active = 1'b0;
            end
        end
        if (!m_active && m_hold_vld) begin
            m_active   = 1'b1;
            m_t        = 0;
            m_byte     = m_hold;
            m_hold_vld = 1'b0;
        end
        if (en) begin
            if (!m_hold_vld) begin
                m_hold_vld = 1'b1;
                m_hold     = wdata;
            end else begin
                e_ovr = 1'b1;
            end
        end
        if (m_active) begin
            b     = m_t / D2;
            e_clk = (m_t % D2) >= D;
            if (b == 0)      e_tx = 1'b0;
            else if (b <= 8) e_tx = m_byte[b-1];
`ifdef USRT_TX_PARITY_EN
            else if (b == 9) e_tx = ^m_byte;
`endif
            else             e_tx = 1'b1;
        end else begin
            e_tx  = 1'b1;
            e_clk = 1'b1;
        end
        e_busy = m_active || m_hold_vld;
    endtask

    initial forever begin
        @(posedge clk);
        if (done === 1'b1) done_cnt++;
        if (ovr === 1'b1) ovr_cnt++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk1("model tx", u_tx, e_tx);
            chk1("model clk", u_clk, e_clk);
            chk1("model busy", busy, e_busy);
            chk1("model done", done, e_done);
            chk1("model ovr", ovr, e_ovr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    function automatic logic [10:0] frame_seq(input logic [7:0] b, input logic pbit);
`ifdef USRT_TX_PARITY_EN
        return {1'b1, pbit, b, 1'b0};
`else
        return {pbit, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic send(input logic [7:0] b);
        en = 1'b1; wdata = b;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Called at the negedge of frame cycle t0; returns at the negedge of cycle FR.
    task automatic check_frame(input logic [10:0] seq, input int t0);
        for (int t = t0; t < NB * D2; t++) begin
            chk1("frame tx", u_tx, seq[t / D2]);
            chk1("frame clk", u_clk, (t % D2) >= D);
            chk1("frame busy", busy, 1'b1);
            @(negedge clk);
        end
        chk1("done at frame end", done, 1'b1);
    endtask

    task automatic send_and_start(input logic [7:0] b);
        send(b);
        chk1("busy after strobe", busy, 1'b1);
        chk1("tx before start", u_tx, 1'b1);
        @(negedge clk);
        chk1("start latency", u_tx, 1'b0);
    endtask

    int c0, o0;

    initial begin
        rst = 1'b1; en = 1'b0; wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk1("reset tx", u_tx, 1'b1);
        chk1("reset clk", u_clk, 1'b1);
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk1("reset ovr", ovr, 1'b0);
        rst = 1'b0;

        c0 = done_cnt; o0 = ovr_cnt;
        repeat (50) begin
            @(negedge clk);
            chk1("idle tx", u_tx, 1'b1);
            chk1("idle clk", u_clk, 1'b1);
            chk1("idle busy", busy, 1'b0);
        end
        chkn("idle done count", done_cnt - c0, 0);
        chkn("idle ovr count", ovr_cnt - o0, 0);

        // Single frame 0xA5 with measured frame length
        c0 = done_cnt;
        send_and_start(8'hA5);
        check_frame(frame_seq(8'hA5, 1'b0), 0);
        @(negedge clk);
        chk1("A5 done width", done, 1'b0);
        chk1("A5 idle tx", u_tx, 1'b1);
        chk1("A5 idle busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chkn("A5 done count", done_cnt - c0, 1);

        // Back-to-back 0x3C then 0xC3 written mid-frame
        c0 = done_cnt; o0 = ovr_cnt;
        send_and_start(8'h3C);
        fork
            check_frame(frame_seq(8'h3C, 1'b0), 0);
            begin
                repeat (10) @(negedge clk);
                send(8'hC3);
            end
        join
        chk1("b2b no gap", u_tx, 1'b0);
        check_frame(frame_seq(8'hC3, 1'b0), 0);
        repeat (3) @(negedge clk);
        chkn("b2b done count", done_cnt - c0, 2);
        chkn("b2b ovr count", ovr_cnt - o0, 0);
        chk1("b2b idle busy", busy, 1'b0);

        // Three consecutive writes: third dropped
        c0 = done_cnt; o0 = ovr_cnt;
        en = 1'b1; wdata = 8'h11;
        @(negedge clk); wdata = 8'h22;
        @(negedge clk); wdata = 8'h33;
        @(negedge clk); en = 1'b0;
        chk1("ovr pulse", ovr, 1'b1);
        check_frame(frame_seq(8'h11, 1'b0), 1);
        check_frame(frame_seq(8'h22, 1'b0), 0);
        repeat (3) @(negedge clk);
        chkn("ovr count", ovr_cnt - o0, 1);
        chkn("ovr done count", done_cnt - c0, 2);

        // Reset during data bit 4 of 0xFF, with a write strobe held during reset
        c0 = done_cnt;
        send_and_start(8'hFF);
        repeat (5 * D2 + 1) @(negedge clk);
        chk1("pre-reset clk", u_clk, 1'b0);
        rst = 1'b1; en = 1'b1; wdata = 8'h55;
        @(negedge clk);
        en = 1'b0;
        chk1("abort tx", u_tx, 1'b1);
        chk1("abort clk", u_clk, 1'b1);
        chk1("abort busy", busy, 1'b0);
        chk1("abort done", done, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk1("post-reset busy", busy, 1'b0);
        chkn("abort done count", done_cnt - c0, 0);
        send_and_start(8'h01);
        check_frame(frame_seq(8'h01, 1'b1), 0);
        repeat (3) @(negedge clk);
        chkn("post-reset done count", done_cnt - c0, 1);

`ifdef USRT_TX_PARITY_EN
        send_and_start(8'h07);
        check_frame(frame_seq(8'h07, 1'b1), 0);
        repeat (3) @(negedge clk);
        send_and_start(8'h03);
        check_frame(frame_seq(8'h03, 1'b0), 0);
        repeat (3) @(negedge clk);
`endif

        chkn("frame length constant", NB * D2, FR);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
